// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64 M-extension multiply/divide unit retiring ITER_BITS bits per cycle.
// Operates on magnitudes (shift-add multiply, restoring divide) and fixes signs on the final cycle.
module muldiv_unit #(
  parameter int XLEN      = 64,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [2:0]      muldiv_func_i,
  input  logic            word_op_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int SH = XLEN - 32;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic [2*XLEN-1:0]   acc_q, acc_d, prod;
  logic [XLEN-1:0]     sh_q, sh_d, opb_q;
  logic [CW-1:0]       cnt_q;
  logic                div_q, rem_q, mulh_q, word_q, negq_q, negr_q;
  logic                is_div, is_mulh, sa, sb, na, nb, dz, ovf, early;
  logic [XLEN-1:0]     ax, bx, ma, mb, early_val, early_res, quo, rmd, val, fin;
  logic [XLEN:0]       r;

  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x, input logic s);
    logic signed [XLEN-1:0] t;
    t = x << SH;
    if (s) return t >>> SH;
    return (x << SH) >> SH;
  endfunction

  always_comb begin
    is_div    = muldiv_func_i[2];
    is_mulh   = !muldiv_func_i[2] && muldiv_func_i[1:0] != 2'd0 && !word_op_i;
    sa        = is_div ? !muldiv_func_i[0] : is_mulh && muldiv_func_i[1:0] != 2'd3;
    sb        = is_div ? !muldiv_func_i[0] : is_mulh && muldiv_func_i[1:0] == 2'd1;
    ax        = word_op_i ? wext(opr_a_i, sa) : opr_a_i;
    bx        = word_op_i ? wext(opr_b_i, sb) : opr_b_i;
    na        = sa && ax[XLEN-1];
    nb        = sb && bx[XLEN-1];
    ma        = na ? -ax : ax;
    mb        = nb ? -bx : bx;
    dz        = bx == '0;
    ovf       = is_div && !muldiv_func_i[0] && (word_op_i ?
                (opr_a_i[31:0] == 32'h8000_0000 && opr_b_i[31:0] == '1) :
                (ax == {1'b1, {(XLEN-1){1'b0}}} && bx == '1));
    early     = is_div && (dz || ovf);
    early_val = muldiv_func_i[1] ? (dz ? ax : '0) : (dz ? '1 : ax);
    early_res = word_op_i ? wext(early_val, 1'b1) : early_val;
  end

  // Each inner step retires one multiplier bit or one quotient bit, MSB first.
  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    r     = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (div_q) begin
        r    = {acc_d[XLEN-1:0], sh_d[XLEN-1]};
        sh_d = sh_d << 1;
        if (r >= {1'b0, opb_q}) begin
          r       = r - {1'b0, opb_q};
          sh_d[0] = 1'b1;
        end
        acc_d = {{(XLEN-1){1'b0}}, r};
      end else begin
        acc_d = (acc_d << 1) + (sh_d[XLEN-1] ? {{XLEN{1'b0}}, opb_q} : '0);
        sh_d  = sh_d << 1;
      end
    end
    prod = negq_q ? -acc_d : acc_d;
    quo  = negq_q ? -sh_d : sh_d;
    rmd  = negr_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    val  = div_q ? (rem_q ? rmd : quo) : (mulh_q ? prod[2*XLEN-1:XLEN] : acc_d[XLEN-1:0]);
    fin  = word_q ? wext(val, 1'b1) : val;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      result_o     <= '0;
      acc_q        <= '0;
      sh_q         <= '0;
      opb_q        <= '0;
      cnt_q        <= '0;
      div_q        <= 1'b0;
      rem_q        <= 1'b0;
      mulh_q       <= 1'b0;
      word_q       <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
    end else if (flush_i) begin
      state_q      <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          div_q       <= is_div;
          rem_q       <= muldiv_func_i[1];
          mulh_q      <= is_mulh;
          word_q      <= word_op_i;
          negq_q      <= (na ^ nb) && !dz;
          negr_q      <= na;
          opb_q       <= is_div ? mb : ma;
          acc_q       <= '0;
          // Word ops left-align the 32-bit operand so the MSB-first loop sees it first.
          sh_q        <= (is_div ? ma : mb) << (word_op_i ? SH : 0);
          cnt_q       <= CW'((word_op_i ? 32 : XLEN) / ITER_BITS - 1);
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          if (early) begin
            state_q      <= DONE;
            resp_valid_o <= 1'b1;
            result_o     <= early_res;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q      <= DONE;
            resp_valid_o <= 1'b1;
            result_o     <= fin;
          end
        end
        DONE: if (resp_ready_i) begin
          state_q      <= IDLE;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=64/ITER_BITS=1 and XLEN=32/ITER_BITS=4).
module tb_muldiv_unit;
  logic clk = 0, resetn = 0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;
  typedef struct { logic [63:0] r; longint t; } exp_t;
  exp_t qa[$], qb[$];

  logic        fl_a = 0, rv_a = 0, w_a = 0, pr_a = 1, rr_a, pv_a, busy_a;
  logic [2:0]  fn_a = 0;
  logic [63:0] ra_a = 0, rb_a = 0, res_a;
  logic        fl_b = 0, rv_b = 0, w_b = 0, pr_b = 1, rr_b, pv_b, busy_b;
  logic [2:0]  fn_b = 0;
  logic [31:0] ra_b = 0, rb_b = 0, res_b;
  bit          seen_a = 0, seen_b = 0, bp_a = 0, bp_b = 0;
  int          hold_a = 0;

  muldiv_unit #(.XLEN(64), .ITER_BITS(1)) dut_a (
    .clk(clk), .resetn(resetn), .flush_i(fl_a), .req_valid_i(rv_a), .req_ready_o(rr_a),
    .opr_a_i(ra_a), .opr_b_i(rb_a), .muldiv_func_i(fn_a), .word_op_i(w_a),
    .resp_valid_o(pv_a), .resp_ready_i(pr_a), .result_o(res_a), .busy_o(busy_a));

  muldiv_unit #(.XLEN(32), .ITER_BITS(4)) dut_b (
    .clk(clk), .resetn(resetn), .flush_i(fl_b), .req_valid_i(rv_b), .req_ready_o(rr_b),
    .opr_a_i(ra_b), .opr_b_i(rb_b), .muldiv_func_i(fn_b), .word_op_i(w_b),
    .resp_valid_o(pv_b), .resp_ready_i(pr_b), .result_o(res_b), .busy_o(busy_b));

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  // Reference: plain wide arithmetic on extended operands.
  function automatic logic [63:0] model(int xl, logic [2:0] f, logic w, logic [63:0] a, logic [63:0] b);
    int wd;
    logic [127:0] m, ua, ub, sa, sb, r;
    wd = (w || xl == 32) ? 32 : 64;
    m  = (128'd1 << wd) - 1;
    ua = {64'd0, a} & m;
    ub = {64'd0, b} & m;
    sa = ua[wd-1] ? ua | ~m : ua;
    sb = ub[wd-1] ? ub | ~m : ub;
    if (!f[2]) begin
      if (w || f == 3'd0) r = ua * ub;
      else r = ((f == 3'd3 ? ua : sa) * (f == 3'd1 ? sb : ub)) >> wd;
    end else if (ub == 0) r = f[1] ? ua : '1;
    else if (!f[0] && ua == (128'd1 << (wd - 1)) && ub == m) r = f[1] ? 128'd0 : ua;
    else if (!f[0]) begin
      if (f[1]) r = $signed(sa) % $signed(sb);
      else r = $signed(sa) / $signed(sb);
    end else r = f[1] ? ua % ub : ua / ub;
    r = r & m;
    if (wd == 32) r = r[31] ? r | ~m : r;
    return r[63:0];
  endfunction

  function automatic longint lat(int xl, int it, logic [2:0] f, logic w, logic [63:0] a, logic [63:0] b);
    int wd;
    logic [63:0] m, ua, ub;
    wd = (w || xl == 32) ? 32 : 64;
    m  = wd == 32 ? 64'hFFFF_FFFF : '1;
    ua = a & m;
    ub = b & m;
    if (f[2] && (ub == 0 || (!f[0] && ua == (64'd1 << (wd - 1)) && ub == m))) return 1;
    return wd / it + 1;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue_a(logic [2:0] f, logic w, logic [63:0] a, logic [63:0] b);
    @(negedge clk);
    fn_a = f; w_a = w; ra_a = a; rb_a = b; rv_a = 1;
    for (int k = 0; k < 300 && !rr_a; k++) @(negedge clk);
    if (!rr_a) chk("accept_timeout_a", rr_a, 1);
    else qa.push_back('{model(64, f, w, a, b), cyc + lat(64, 1, f, w, a, b)});
    @(posedge clk);
    #1 rv_a = 0;
  endtask

  task automatic issue_b(logic [2:0] f, logic w, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    fn_b = f; w_b = w; ra_b = a; rb_b = b; rv_b = 1;
    for (int k = 0; k < 100 && !rr_b; k++) @(negedge clk);
    if (!rr_b) chk("accept_timeout_b", rr_b, 1);
    else qb.push_back('{model(32, f, w, {32'd0, a}, {32'd0, b}), cyc + lat(32, 4, f, w, {32'd0, a}, {32'd0, b})});
    @(posedge clk);
    #1 rv_b = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) chk("drain_timeout", 64'(qa.size() + qb.size()), 0);
  endtask

  always @(negedge clk) if (resetn) begin
    if (qa.size() == 0) begin
      if (pv_a) chk("spurious_resp_a", pv_a, 0);
    end else if (pv_a) begin
      if (!seen_a) begin
        seen_a = 1;
        chk("latency_a", cyc, qa[0].t);
      end
      chk("result_a", res_a, qa[0].r);
      chk("req_ready_in_done_a", rr_a, 0);
    end
    pr_a = (pv_a && hold_a > 0) ? 1'b0 : (bp_a ? 1'($urandom_range(0, 1)) : 1'b1);
    if (pv_a && hold_a > 0) hold_a--;
    if (pv_a && pr_a && qa.size() != 0) begin
      void'(qa.pop_front());
      seen_a = 0;
    end
  end

  always @(negedge clk) if (resetn) begin
    if (qb.size() == 0) begin
      if (pv_b) chk("spurious_resp_b", pv_b, 0);
    end else if (pv_b) begin
      if (!seen_b) begin
        seen_b = 1;
        chk("latency_b", cyc, qb[0].t);
      end
      chk("result_b", {32'd0, res_b}, {32'd0, qb[0].r[31:0]});
    end
    pr_b = bp_b ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pv_b && pr_b && qb.size() != 0) begin
      void'(qb.pop_front());
      seen_b = 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_req_ready", rr_a, 1);
    chk("reset_resp_valid", pv_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_result", res_a, 0);
    resetn = 1;
    issue_a(3'd4, 0, -64'sd7, 64'd2);
    issue_a(3'd6, 0, -64'sd7, 64'd2);
    issue_a(3'd5, 0, 64'd1234, 64'd0);
    issue_a(3'd4, 0, 64'h8000_0000_0000_0000, '1);
    issue_a(3'd6, 1, 64'd5, 64'd0);
    issue_a(3'd1, 0, '1, '1);
    issue_a(3'd3, 0, '1, '1);
    issue_a(3'd0, 1, 64'h7FFF_FFFF, 64'd2);
    issue_a(3'd4, 1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF);
    issue_a(3'd2, 0, '1, '1);
    drain();
    hold_a = 10;
    issue_a(3'd4, 0, 64'd1000, 64'd7);
    drain();
    @(negedge clk);
    fn_a = 3'd4; w_a = 0; ra_a = 64'd999; rb_a = 64'd3; rv_a = 1;
    @(posedge clk);
    #1 rv_a = 0;
    repeat (44) @(negedge clk);
    chk("busy_before_flush", busy_a, 1);
    fl_a = 1;
    @(posedge clk);
    #1 fl_a = 0;
    @(negedge clk);
    chk("flush_busy", busy_a, 0);
    chk("flush_req_ready", rr_a, 1);
    chk("flush_resp_valid", pv_a, 0);
    fl_a = 1; rv_a = 1;
    @(posedge clk);
    #1 fl_a = 0; rv_a = 0;
    @(negedge clk);
    chk("flush_blocks_accept", busy_a, 0);
    repeat (70) @(negedge clk);
    issue_a(3'd4, 0, 64'd100, 64'd7);
    drain();
    @(negedge clk);
    fn_a = 3'd4; ra_a = 64'd100; rb_a = 64'd3; rv_a = 1;
    @(posedge clk);
    #1 rv_a = 0;
    repeat (10) @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("midop_reset_req_ready", rr_a, 1);
    chk("midop_reset_resp_valid", pv_a, 0);
    chk("midop_reset_busy", busy_a, 0);
    chk("midop_reset_result", res_a, 0);
    @(negedge clk);
    resetn = 1;
    seen_a = 0;
    bp_a = 1;
    for (int n = 0; n < 150; n++)
      issue_a(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
    drain();
    issue_b(3'd4, 0, 32'hFFFF_FFF9, 32'd2);
    issue_b(3'd7, 0, 32'd9, 32'd0);
    issue_b(3'd6, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue_b(3'd1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bp_b = 1;
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] x, y;
      x = rnd_op();
      y = rnd_op();
      issue_b(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), x[31:0], y[31:0]);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
